// File: rtl/set_cover_counter_n.sv
// set_cover_counter_n
// Scans a GRID x GRID lattice (points 1..GRID on each axis), one point per cycle,
// tests each point against NUM_SET circles and counts the points that satisfy
// the selected set-combination rule (union, intersection, odd parity, exactly-k).
// Pipeline: S0 point registers -> S1 registered hit vector -> S2 rule + accumulate.
// Optional macro SET_HIT_STREAM_EN adds a per-point hit stream (hit_vld/hit/hit_x/hit_y).
//
// state  | meaning
// IDLE   | waiting for en; result held on candidate
// SCAN   | issuing GRID*GRID points in x-fastest raster order
// DRAIN  | two cycles letting S1/S2 finish the last points
// DONE   | one cycle; next edge raises valid and drops busy
module set_cover_counter_n #(
  parameter int NUM_SET = 3,
  parameter int COORD_W = 4,
  parameter int GRID    = 8,
  parameter int CNT_W   = $clog2(GRID*GRID+1),
  parameter int K_W     = $clog2(NUM_SET+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_SET*2*COORD_W-1:0] central,
  input  logic [NUM_SET*COORD_W-1:0]   radius,
  input  logic [NUM_SET-1:0]           set_mask,
  input  logic [1:0]                   mode,
  input  logic [K_W-1:0]               k,
`ifdef SET_HIT_STREAM_EN
  output logic                         hit_vld,
  output logic                         hit,
  output logic [COORD_W-1:0]           hit_x,
  output logic [COORD_W-1:0]           hit_y,
`endif
  output logic                         busy,
  output logic                         valid,
  output logic [CNT_W-1:0]             candidate
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int D2_W = 2*COORD_W+3;
  localparam logic [CNT_W-1:0]   SCAN_LAST = CNT_W'(GRID*GRID-1);
  localparam logic [COORD_W-1:0] GRID_C    = COORD_W'(GRID);
  localparam logic [COORD_W-1:0] ONE_C     = COORD_W'(1);

  logic [1:0]                   state;
  logic [CNT_W-1:0]             scan_cnt;
  logic                         drain_cnt;
  logic [NUM_SET*2*COORD_W-1:0] job_central;
  logic [NUM_SET*2*COORD_W-1:0] job_r2;
  logic [NUM_SET*2*COORD_W-1:0] r2_in;
  logic [NUM_SET-1:0]           job_mask;
  logic [1:0]                   job_mode;
  logic [K_W-1:0]               job_k;
  logic                         s0_vld;
  logic [COORD_W-1:0]           s0_x;
  logic [COORD_W-1:0]           s0_y;
  logic                         s1_vld;
  logic [NUM_SET-1:0]           s1_hit;
  logic [NUM_SET-1:0]           hit_comb;
  logic [K_W-1:0]               pop;
  logic                         rule;
  logic                         capture;

  assign capture = (state == ST_IDLE) && en && !busy;

  // Square each incoming radius so S1 compares squared distances without a sqrt.
  always_comb begin
    r2_in = '0;
    for (int i = 0; i < NUM_SET; i++) begin
      r2_in[(NUM_SET-i)*2*COORD_W-1 -: 2*COORD_W] =
        {{COORD_W{1'b0}}, radius[(NUM_SET-i)*COORD_W-1 -: COORD_W]} *
        {{COORD_W{1'b0}}, radius[(NUM_SET-i)*COORD_W-1 -: COORD_W]};
    end
  end

  // Sequencer: job capture, raster point generation (S0) and the done handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      scan_cnt    <= '0;
      drain_cnt   <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      job_central <= '0;
      job_r2      <= '0;
      job_mask    <= '0;
      job_mode    <= '0;
      job_k       <= '0;
      s0_vld      <= 1'b0;
      s0_x        <= '0;
      s0_y        <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (capture) begin
            job_central <= central;
            job_r2      <= r2_in;
            job_mask    <= set_mask;
            job_mode    <= mode;
            job_k       <= k;
            busy        <= 1'b1;
            scan_cnt    <= SCAN_LAST;
            s0_x        <= ONE_C;
            s0_y        <= ONE_C;
            s0_vld      <= 1'b1;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_cnt == '0) begin
            s0_vld    <= 1'b0;
            drain_cnt <= 1'b1;
            state     <= ST_DRAIN;
          end else begin
            scan_cnt <= scan_cnt - CNT_W'(1);
            if (s0_x == GRID_C) begin
              s0_x <= ONE_C;
              s0_y <= s0_y + ONE_C;
            end else begin
              s0_x <= s0_x + ONE_C;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 1'b0) state <= ST_DONE;
          else                   drain_cnt <= 1'b0;
        end
        default: begin
          busy  <= 1'b0;
          valid <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-set squared-distance test of the S0 point; full-width d2 so nothing wraps.
  always_comb begin
    logic [COORD_W-1:0]        cx, cy;
    logic signed [COORD_W+1:0] dx, dy;
    logic [COORD_W+1:0]        adx, ady;
    logic [D2_W-1:0]           wx, wy, d2, r2w;
    hit_comb = '0;
    for (int i = 0; i < NUM_SET; i++) begin
      cx  = job_central[(NUM_SET-i)*2*COORD_W-1 -: COORD_W];
      cy  = job_central[(NUM_SET-i)*2*COORD_W-COORD_W-1 -: COORD_W];
      dx  = signed'({2'b00, s0_x}) - signed'({2'b00, cx});
      dy  = signed'({2'b00, s0_y}) - signed'({2'b00, cy});
      adx = dx[COORD_W+1] ? unsigned'(-dx) : unsigned'(dx);
      ady = dy[COORD_W+1] ? unsigned'(-dy) : unsigned'(dy);
      wx  = {{(COORD_W+1){1'b0}}, adx};
      wy  = {{(COORD_W+1){1'b0}}, ady};
      d2  = wx*wx + wy*wy;
      r2w = {3'b000, job_r2[(NUM_SET-i)*2*COORD_W-1 -: 2*COORD_W]};
      hit_comb[i] = (d2 <= r2w) & job_mask[i];
    end
  end

  // S1: register the masked hit vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_hit <= '0;
    end else begin
      s1_vld <= s0_vld;
      s1_hit <= hit_comb;
    end
  end

  // Set-combination rule on the registered hit vector.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SET; i++) pop = pop + K_W'(s1_hit[i]);
    case (job_mode)
      2'd0:    rule = |s1_hit;
      2'd1:    rule = (&(s1_hit | ~job_mask)) & (|job_mask);
      2'd2:    rule = ^s1_hit;
      default: rule = (pop == job_k);
    endcase
  end

  // S2: accumulate; cleared on capture, otherwise held as the job result.
  always_ff @(posedge clk) begin
    if (rst)                  candidate <= '0;
    else if (capture)         candidate <= '0;
    else if (s1_vld && rule)  candidate <= candidate + CNT_W'(1);
  end

`ifdef SET_HIT_STREAM_EN
  logic [COORD_W-1:0] s1_x;
  logic [COORD_W-1:0] s1_y;

  // Per-point hit stream, aligned with the S2 accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x    <= '0;
      s1_y    <= '0;
      hit_vld <= 1'b0;
      hit     <= 1'b0;
      hit_x   <= '0;
      hit_y   <= '0;
    end else begin
      s1_x    <= s0_x;
      s1_y    <= s0_y;
      hit_vld <= s1_vld;
      hit     <= s1_vld & rule;
      hit_x   <= s1_x;
      hit_y   <= s1_y;
    end
  end
`endif

endmodule

// File: tb/tb_set_cover_counter_n.sv
// Directed bench for set_cover_counter_n (NUM_SET=3, COORD_W=4, GRID=8).
module tb_set_cover_counter_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [2:0]  set_mask;
  logic [1:0]  mode;
  logic [1:0]  k;
  logic        busy;
  logic        valid;
  logic [6:0]  candidate;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef SET_HIT_STREAM_EN
  logic       hit_vld;
  logic       hit;
  logic [3:0] hit_x;
  logic [3:0] hit_y;
  int s_cnt = 0;
  int s_sum = 0;
  int s_order_err = 0;
  int ex_x = 1;
  int ex_y = 1;

  // Monitor the first job's hit stream: raster order, count and hit sum.
  always @(posedge clk) begin
    #1;
    if (hit_vld && s_cnt < 64) begin
      if (int'(hit_x) != ex_x || int'(hit_y) != ex_y) s_order_err++;
      s_sum += int'(hit);
      s_cnt++;
      if (ex_x == 8) begin ex_x = 1; ex_y++; end
      else ex_x++;
    end
  end
`endif

  set_cover_counter_n dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
    .set_mask(set_mask), .mode(mode), .k(k),
`ifdef SET_HIT_STREAM_EN
    .hit_vld(hit_vld), .hit(hit), .hit_x(hit_x), .hit_y(hit_y),
`endif
    .busy(busy), .valid(valid), .candidate(candidate)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a job; optionally pulse en at cycle poke (0 = never). Checks latency,
  // busy/valid timing and the result, plus one cycle of result hold.
  task automatic run_job(input string tag, input logic [23:0] c, input logic [11:0] r,
                         input logic [2:0] m, input logic [1:0] md, input logic [1:0] kk,
                         input int exp_cnt, input int poke);
    int lat;
    central = c; radius = r; set_mask = m; mode = md; k = kk; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    chk({tag, "_busy_start"}, int'(busy), 1);
    chk({tag, "_cand_clr"}, int'(candidate), 0);
    lat = 0;
    for (int i = 1; i <= 200 && lat == 0; i++) begin
      @(posedge clk); #1;
      en = 1'b0;
      if (valid) lat = i;
      if (i == poke) begin
        en = 1'b1; set_mask = 3'b111; radius = 12'hFFF; mode = 2'd1; central = 24'h123456;
      end
    end
    chk({tag, "_latency"}, lat, 67);
    chk({tag, "_busy_at_valid"}, int'(busy), 0);
    chk({tag, "_cand"}, int'(candidate), exp_cnt);
    @(posedge clk); #1;
    chk({tag, "_valid_1cyc"}, int'(valid), 0);
    chk({tag, "_cand_hold"}, int'(candidate), exp_cnt);
  endtask

  initial begin
    int vcount;
    rst = 1'b1; en = 1'b0; central = '0; radius = '0; set_mask = '0; mode = '0; k = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_cand", int'(candidate), 0);

    run_job("single", 24'h440000, 12'h200, 3'b001, 2'd0, 2'd0, 13, 0);
`ifdef SET_HIT_STREAM_EN
    chk("stream_count", s_cnt, 64);
    chk("stream_sum", s_sum, 13);
    chk("stream_order", s_order_err, 0);
`endif
    run_job("two_and", 24'h444400, 12'h210, 3'b011, 2'd1, 2'd0, 5, 0);
    run_job("two_xor", 24'h444400, 12'h210, 3'b011, 2'd2, 2'd0, 8, 0);
    run_job("two_k1",  24'h444400, 12'h210, 3'b011, 2'd3, 2'd1, 8, 0);
    run_job("off_k0",  24'h000000, 12'h000, 3'b111, 2'd3, 2'd0, 64, 0);
    run_job("and_m0",  24'h000000, 12'h000, 3'b000, 2'd1, 2'd0, 0, 0);
    run_job("full",    24'h880000, 12'hF00, 3'b001, 2'd0, 2'd0, 64, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("full_hold", int'(candidate), 64);

    run_job("poke", 24'h440000, 12'h200, 3'b001, 2'd0, 2'd0, 13, 10);

    // Abort a job with rst at cycle 30; no valid may follow.
    central = 24'h440000; radius = 12'h200; set_mask = 3'b001; mode = 2'd0; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_cand", int'(candidate), 0);
    vcount = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    chk("abort_no_valid", vcount, 0);
    run_job("after_abort", 24'h440000, 12'h200, 3'b001, 2'd0, 2'd0, 13, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
